// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states, trap codes and opcode decode helpers
// shared by the ALU sequencer and its MULS step counter.
package alu_pkg;

  localparam logic [6:0] OP_SLL        = 7'd1;
  localparam logic [6:0] OP_SRL        = 7'd2;
  localparam logic [6:0] OP_SRA        = 7'd3;
  localparam logic [6:0] OP_AND        = 7'd4;
  localparam logic [6:0] OP_ANDCC      = 7'd5;
  localparam logic [6:0] OP_ANDN       = 7'd6;
  localparam logic [6:0] OP_ANDNCC     = 7'd7;
  localparam logic [6:0] OP_OR         = 7'd8;
  localparam logic [6:0] OP_ORCC       = 7'd9;
  localparam logic [6:0] OP_ORN        = 7'd10;
  localparam logic [6:0] OP_ORNCC      = 7'd11;
  localparam logic [6:0] OP_XOR        = 7'd12;
  localparam logic [6:0] OP_XORCC      = 7'd13;
  localparam logic [6:0] OP_ADD        = 7'd14;
  localparam logic [6:0] OP_ADDCC      = 7'd15;
  localparam logic [6:0] OP_ADDX       = 7'd16;
  localparam logic [6:0] OP_ADDXCC     = 7'd17;
  localparam logic [6:0] OP_TADDCC     = 7'd18;
  localparam logic [6:0] OP_TADDCCTV   = 7'd19;
  localparam logic [6:0] OP_SUB        = 7'd20;
  localparam logic [6:0] OP_SUBCC      = 7'd21;
  localparam logic [6:0] OP_SUBX       = 7'd22;
  localparam logic [6:0] OP_SUBXCC     = 7'd23;
  localparam logic [6:0] OP_TSUBCC     = 7'd24;
  localparam logic [6:0] OP_TSUBCCTV   = 7'd25;
  localparam logic [6:0] OP_MULSCC     = 7'd26;
  localparam logic [6:0] OP_UMUL       = 7'd27;
  localparam logic [6:0] OP_UMULCC     = 7'd28;
  localparam logic [6:0] OP_UDIV       = 7'd29;
  localparam logic [6:0] OP_UDIVCC     = 7'd30;
  localparam logic [6:0] OP_SDIV       = 7'd31;
  localparam logic [6:0] OP_SDIVCC     = 7'd32;
  localparam logic [6:0] OP_SMUL       = 7'd33;
  localparam logic [6:0] OP_SMULCC     = 7'd34;
  localparam logic [6:0] OP_DBZ_HANDLE = 7'd35;
  localparam logic [6:0] OP_TOF_HANDLE = 7'd36;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'b00,
    TRAP_DBZ  = 2'b01,
    TRAP_TOF  = 2'b10,
    TRAP_ILL  = 2'b11
  } trap_e;

  typedef enum logic [2:0] {
    ST_INIT_D,
    ST_INIT_T,
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_TRAP,
    ST_RESP
  } state_e;

  function automatic logic is_legal(input logic [6:0] op);
    return (op != 7'd0) && (op <= OP_SMULCC);
  endfunction

  function automatic logic is_cc(input logic [6:0] op);
    logic r;
    case (op)
      OP_ANDCC, OP_ANDNCC, OP_ORCC, OP_ORNCC, OP_XORCC,
      OP_ADDCC, OP_ADDXCC, OP_TADDCC, OP_TADDCCTV,
      OP_SUBCC, OP_SUBXCC, OP_TSUBCC, OP_TSUBCCTV,
      OP_MULSCC, OP_UMULCC, OP_UDIVCC, OP_SDIVCC,
      OP_SMULCC: r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic writes_y(input logic [6:0] op);
    logic r;
    case (op)
      OP_MULSCC, OP_UMUL, OP_UMULCC,
      OP_SMUL, OP_SMULCC: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muls_counter.sv
// alu_muls_counter: MULS step counter, saturating at MUL_STEPS.
// Ports: clr_i restarts at 0, inc_i advances, last_o/pre_last_o flag steps.
module alu_muls_counter
  import alu_pkg::*;
#(
  parameter int MUL_STEPS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o,
  output logic pre_last_o
);

  localparam int CW = $clog2(MUL_STEPS + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o     = (cnt_q == CW'(MUL_STEPS));
  assign pre_last_o = (cnt_q == CW'(MUL_STEPS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: req/resp sequencer in front of the integer ALU; owns ICC/Y,
// clears sticky ALU traps via handler opcodes, expands MULS into MULScc steps.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_op,
  input  logic        req_muls,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] resp_y,
  output logic [3:0]  resp_icc,
  output logic [1:0]  resp_trap,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic [6:0]  alu_instruction,
  output logic        alu_operate,
  output logic [3:0]  alu_icc_in,
  output logic [31:0] alu_y_in,
  input  logic [31:0] alu_rd,
  input  logic [3:0]  alu_icc_out,
  input  logic [31:0] alu_y_out,
  input  logic        alu_dbz,
  input  logic        alu_tof
);

  state_e      state_q;
  trap_e       trap_q;
  logic [3:0]  icc_q;
  logic [31:0] y_q;
  logic [31:0] r1_q;
  logic [31:0] r2_q;
  logic [6:0]  op_q;
  logic        operate_q;
  logic        mul_q;
  logic        tof_pend_q;
  logic        valid_q;
  logic [31:0] data_q;

  logic trap_hit;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;
  logic cnt_pre_last;

  assign trap_hit = alu_dbz | alu_tof;
  assign cnt_clr  = (state_q == ST_IDLE) & req_valid & req_muls;
  assign cnt_inc  = (state_q == ST_CAPTURE) & mul_q & ~trap_hit;

  alu_muls_counter #(
    .MUL_STEPS (MUL_STEPS)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .last_o     (cnt_last),
    .pre_last_o (cnt_pre_last)
  );

  assign req_ready       = (state_q == ST_IDLE);
  assign resp_valid      = valid_q;
  assign resp_data       = data_q;
  assign resp_y          = y_q;
  assign resp_icc        = icc_q;
  assign resp_trap       = trap_q;
  assign alu_r1          = r1_q;
  assign alu_r2          = r2_q;
  assign alu_instruction = op_q;
  assign alu_operate     = operate_q;
  assign alu_icc_in      = icc_q;
  assign alu_y_in        = y_q;

  // During MULS r1_q doubles as the running accumulator (high word).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT_D;
      trap_q     <= TRAP_NONE;
      icc_q      <= '0;
      y_q        <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      op_q       <= '0;
      operate_q  <= 1'b0;
      mul_q      <= 1'b0;
      tof_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      operate_q <= 1'b0;
      unique case (state_q)
        ST_INIT_D: begin
          op_q      <= OP_DBZ_HANDLE;
          operate_q <= 1'b1;
          state_q   <= ST_INIT_T;
        end
        ST_INIT_T: begin
          op_q      <= OP_TOF_HANDLE;
          operate_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_valid) begin
            mul_q <= req_muls;
            if (req_muls) begin
              y_q       <= req_b;
              icc_q     <= '0;
              r1_q      <= '0;
              r2_q      <= req_a;
              op_q      <= OP_MULSCC;
              operate_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end else if (!is_legal(req_op)) begin
              trap_q  <= TRAP_ILL;
              data_q  <= '0;
              valid_q <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              op_q      <= req_op;
              r1_q      <= req_a;
              r2_q      <= req_b;
              operate_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (trap_hit) begin
            // DBZ wins the code and is cleared first.
            trap_q     <= alu_dbz ? TRAP_DBZ : TRAP_TOF;
            tof_pend_q <= alu_dbz & alu_tof;
            op_q       <= alu_dbz ? OP_DBZ_HANDLE : OP_TOF_HANDLE;
            operate_q  <= 1'b1;
            data_q     <= '0;
            state_q    <= ST_TRAP;
          end else if (mul_q) begin
            r1_q  <= alu_rd;
            y_q   <= alu_y_out;
            icc_q <= alu_icc_out;
            if (cnt_last) begin
              data_q  <= alu_rd;
              trap_q  <= TRAP_NONE;
              valid_q <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              // The final step shifts with a zero addend.
              if (cnt_pre_last) begin
                r2_q <= '0;
              end
              operate_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end else begin
            data_q <= alu_rd;
            trap_q <= TRAP_NONE;
            if (is_cc(op_q)) begin
              icc_q <= alu_icc_out;
            end
            if (writes_y(op_q)) begin
              y_q <= alu_y_out;
            end
            valid_q <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_TRAP: begin
          if (tof_pend_q) begin
            tof_pend_q <= 1'b0;
            op_q       <= OP_TOF_HANDLE;
            operate_q  <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a small
// registered ALU model behind it.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_op;
  logic        req_muls;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_y;
  logic [3:0]  resp_icc;
  logic [1:0]  resp_trap;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic [6:0]  alu_instruction;
  logic        alu_operate;
  logic [3:0]  alu_icc_in;
  logic [31:0] alu_y_in;
  logic [31:0] m_rd  = '0;
  logic [3:0]  m_icc = '0;
  logic [31:0] m_y   = '0;
  logic        m_dbz = 1'b0;
  logic        m_tof = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_muls        (req_muls),
    .req_a           (req_a),
    .req_b           (req_b),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .resp_y          (resp_y),
    .resp_icc        (resp_icc),
    .resp_trap       (resp_trap),
    .alu_r1          (alu_r1),
    .alu_r2          (alu_r2),
    .alu_instruction (alu_instruction),
    .alu_operate     (alu_operate),
    .alu_icc_in      (alu_icc_in),
    .alu_y_in        (alu_y_in),
    .alu_rd          (m_rd),
    .alu_icc_out     (m_icc),
    .alu_y_out       (m_y),
    .alu_dbz         (m_dbz),
    .alu_tof         (m_tof)
  );

  // ALU model: add with NZVC, SPARC MULScc, UDIV by zero, tagged add.
  logic [32:0] add_s;
  logic        add_v;
  logic [31:0] ms_sh;
  logic [31:0] ms_ad;
  logic [32:0] ms_s;
  logic        ms_v;

  always_comb begin
    add_s = {1'b0, alu_r1} + {1'b0, alu_r2};
    add_v = (alu_r1[31] == alu_r2[31]) && (add_s[31] != alu_r1[31]);
    ms_sh = {alu_icc_in[3] ^ alu_icc_in[1], alu_r1[31:1]};
    ms_ad = alu_y_in[0] ? alu_r2 : 32'd0;
    ms_s  = {1'b0, ms_sh} + {1'b0, ms_ad};
    ms_v  = (ms_sh[31] == ms_ad[31]) && (ms_s[31] != ms_sh[31]);
  end

  always @(posedge clk) begin
    if (alu_operate) begin
      case (alu_instruction)
        7'd14, 7'd15: begin
          m_rd  <= add_s[31:0];
          m_icc <= {add_s[31], add_s[31:0] == 32'd0, add_v, add_s[32]};
          m_y   <= 32'hDEADBEEF;
        end
        7'd26: begin
          m_rd  <= ms_s[31:0];
          m_icc <= {ms_s[31], ms_s[31:0] == 32'd0, ms_v, ms_s[32]};
          m_y   <= {alu_r1[0], alu_y_in[31:1]};
        end
        7'd29: begin
          if (alu_r2 == 32'd0) m_dbz <= 1'b1;
          m_rd  <= 32'h12345678;
          m_icc <= 4'hF;
          m_y   <= 32'hDEADBEEF;
        end
        7'd19: begin
          if (alu_r1[1:0] != 2'd0 || alu_r2[1:0] != 2'd0) m_tof <= 1'b1;
          m_rd  <= add_s[31:0];
          m_icc <= 4'hF;
          m_y   <= 32'hDEADBEEF;
        end
        7'd35: m_dbz <= 1'b0;
        7'd36: m_tof <= 1'b0;
        default: begin
          m_rd  <= alu_r1 ^ alu_r2;
          m_icc <= 4'hF;
          m_y   <= 32'hDEADBEEF;
        end
      endcase
    end
  end

  int          op_cnt  = 0;
  int          mul_iss = 0;
  int          mul_nz  = 0;
  logic [31:0] last_r2 = '0;

  always @(posedge clk) begin
    if (alu_operate) begin
      op_cnt <= op_cnt + 1;
      if (alu_instruction == 7'd26) begin
        mul_iss <= mul_iss + 1;
        if (alu_r2 == 32'd3) mul_nz <= mul_nz + 1;
        last_r2 <= alu_r2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_muls  = 1'b0;
  endtask

  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk(tag, {31'd0, req_ready}, 32'd1);
  endtask

  int n;
  int mi;
  int mn;
  int edges;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_muls   = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) step();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_y", resp_y, 32'd0);
    chk("rst_icc", {28'd0, resp_icc}, 32'd0);
    chk("rst_trap", {30'd0, resp_trap}, 32'd0);
    chk("rst_operate", {31'd0, alu_operate}, 32'd0);
    rst = 1'b0;

    step();
    chk("init1_op", {31'd0, alu_operate}, 32'd1);
    chk("init1_ins", {25'd0, alu_instruction}, 32'd35);
    chk("init1_rdy", {31'd0, req_ready}, 32'd0);
    step();
    chk("init2_op", {31'd0, alu_operate}, 32'd1);
    chk("init2_ins", {25'd0, alu_instruction}, 32'd36);
    chk("init2_rdy", {31'd0, req_ready}, 32'd1);

    issue(7'd14, 32'hFFFFFFFF, 32'd2);
    chk("add_op", {31'd0, alu_operate}, 32'd1);
    chk("add_ins", {25'd0, alu_instruction}, 32'd14);
    chk("add_rdy", {31'd0, req_ready}, 32'd0);
    step();
    chk("add_v_e1", {31'd0, resp_valid}, 32'd0);
    step();
    chk("add_v_e2", {31'd0, resp_valid}, 32'd1);
    chk("add_data", resp_data, 32'd1);
    chk("add_icc", {28'd0, resp_icc}, 32'd0);
    chk("add_y", resp_y, 32'd0);
    chk("add_trap", {30'd0, resp_trap}, 32'd0);
    release_resp("add_idle");
    chk("add_v_off", {31'd0, resp_valid}, 32'd0);

    issue(7'd15, 32'hFFFFFFFF, 32'd2);
    repeat (2) step();
    chk("addcc_v", {31'd0, resp_valid}, 32'd1);
    chk("addcc_data", resp_data, 32'd1);
    chk("addcc_icc", {28'd0, resp_icc}, 32'd1);
    n = op_cnt;
    repeat (5) begin
      step();
      chk("stall_v", {31'd0, resp_valid}, 32'd1);
      chk("stall_data", resp_data, 32'd1);
      chk("stall_icc", {28'd0, resp_icc}, 32'd1);
      chk("stall_rdy", {31'd0, req_ready}, 32'd0);
    end
    chk("stall_noop", op_cnt, n);
    release_resp("stall_idle");

    issue(7'd29, 32'd10, 32'd0);
    repeat (2) step();
    chk("dbz_op", {31'd0, alu_operate}, 32'd1);
    chk("dbz_ins", {25'd0, alu_instruction}, 32'd35);
    step();
    chk("dbz_v", {31'd0, resp_valid}, 32'd1);
    chk("dbz_trap", {30'd0, resp_trap}, 32'd1);
    chk("dbz_data", resp_data, 32'd0);
    chk("dbz_icc", {28'd0, resp_icc}, 32'd1);
    chk("dbz_y", resp_y, 32'd0);
    release_resp("dbz_idle");

    issue(7'd19, 32'd1, 32'd0);
    repeat (2) step();
    chk("tof_op", {31'd0, alu_operate}, 32'd1);
    chk("tof_ins", {25'd0, alu_instruction}, 32'd36);
    step();
    chk("tof_trap", {30'd0, resp_trap}, 32'd2);
    chk("tof_icc", {28'd0, resp_icc}, 32'd1);
    release_resp("tof_idle");

    mi = mul_iss;
    mn = mul_nz;
    req_muls = 1'b1;
    issue(7'd0, 32'd3, 32'd5);
    chk("muls_y0", resp_y, 32'd5);
    chk("muls_icc0", {28'd0, resp_icc}, 32'd0);
    edges = 0;
    while (!resp_valid && edges < 100) begin
      step();
      edges++;
    end
    chk("muls_edge", edges, 32'd66);
    chk("muls_iss", mul_iss - mi, 32'd33);
    chk("muls_nz", mul_nz - mn, 32'd32);
    chk("muls_lastr2", last_r2, 32'd0);
    chk("muls_hi", resp_data, 32'd0);
    chk("muls_lo", resp_y, 32'd15);
    chk("muls_icc", {28'd0, resp_icc}, 32'd4);
    chk("muls_trap", {30'd0, resp_trap}, 32'd0);
    release_resp("muls_idle");

    n = op_cnt;
    issue(7'h50, 32'd1, 32'd1);
    chk("ill_v", {31'd0, resp_valid}, 32'd1);
    chk("ill_trap", {30'd0, resp_trap}, 32'd3);
    chk("ill_data", resp_data, 32'd0);
    chk("ill_y", resp_y, 32'd15);
    release_resp("ill_idle");
    issue(7'd35, 32'd1, 32'd1);
    chk("rsv_trap", {30'd0, resp_trap}, 32'd3);
    release_resp("rsv_idle");
    chk("ill_noop", op_cnt, n);

    issue(7'd14, 32'd1, 32'd1);
    rst = 1'b1;
    step();
    chk("abort_v", {31'd0, resp_valid}, 32'd0);
    chk("abort_y", resp_y, 32'd0);
    chk("abort_rdy", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
